// File: rtl/lime_control_mc.sv
// lime_control_mc: multi-cycle control FSM for the lime 16-bit core.
// Decodes {func, opcode} and sequences fetch/decode/execute/mem/wb.
// Ports:
//   CLK, Reset          clock (rising), async active-high reset
//   input_control       {func, opcode} from the instruction register
//   mem_ready           memory finishes the current access this cycle
//   halt_req            stop at the next instruction boundary
//   trap_clear          one-cycle pulse that leaves TRAP
//   mem_req             a memory access is active
//   MemR..keepALUOut    datapath strobes
//   IoD, ALUSrcA/B      address / ALU operand selects
//   BranchType, ALUOp   branch condition and ALU operation
//   current_state       raw state encoding for debug
//   trap, trap_cause    trap flag, cause (01 illegal, 10 timeout)
//   halted              parked in HALT
//   instr_retired       retired-instruction counter (wraps)
module lime_control_mc #(
  parameter int FUNC_W   = 4,
  parameter int OPC_W    = 3,
  parameter int ALUOP_W  = 4,
  parameter int MAX_WAIT = 15,
  parameter int RETIRE_W = 16
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [FUNC_W+OPC_W-1:0] input_control,
  input  logic                    mem_ready,
  input  logic                    halt_req,
  input  logic                    trap_clear,
  output logic                    mem_req,
  output logic                    MemR,
  output logic                    MemW,
  output logic                    IRWrite,
  output logic                    PCWrite,
  output logic                    PCSrc,
  output logic                    RegWrite,
  output logic                    Mem2Reg,
  output logic                    Branch,
  output logic                    keepALUOut,
  output logic [1:0]              IoD,
  output logic [2:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              BranchType,
  output logic [ALUOP_W-1:0]      ALUOp,
  output logic [4:0]              current_state,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output logic                    halted,
  output logic [RETIRE_W-1:0]     instr_retired
);

  localparam logic [4:0] S_FETCH    = 5'd0;
  localparam logic [4:0] S_DECODE   = 5'd1;
  localparam logic [4:0] S_RTYPE    = 5'd2;
  localparam logic [4:0] S_RITYPE   = 5'd3;
  localparam logic [4:0] S_RTYPEEND = 5'd4;
  localparam logic [4:0] S_LW1      = 5'd5;
  localparam logic [4:0] S_LW2      = 5'd6;
  localparam logic [4:0] S_SW       = 5'd7;
  localparam logic [4:0] S_JALR     = 5'd8;
  localparam logic [4:0] S_BRANCH   = 5'd9;
  localparam logic [4:0] S_BRANCH2  = 5'd10;
  localparam logic [4:0] S_JAL      = 5'd11;
  localparam logic [4:0] S_LAS1     = 5'd12;
  localparam logic [4:0] S_LAS2     = 5'd13;
  localparam logic [4:0] S_LAS3     = 5'd14;
  localparam logic [4:0] S_TRAP     = 5'd15;
  localparam logic [4:0] S_HALT     = 5'd16;

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_J   = ALUOP_W'(12);

  localparam logic [1:0] C_ILL = 2'b01;
  localparam logic [1:0] C_TMO = 2'b10;

  // With the timeout disabled the counter only needs to show
  // "not the entry cycle", so it saturates at 1.
  localparam int CNT_MAX = (MAX_WAIT == 0) ? 1 : MAX_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [4:0]        state;
  logic [4:0]        state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [FUNC_W-1:0] func;
  logic [OPC_W-1:0]  opc;
  logic              is_mem;
  logic              halting;
  logic              timeout;
  logic              retire;

  assign func = input_control[FUNC_W+OPC_W-1 -: FUNC_W];
  assign opc  = input_control[OPC_W-1:0];

  assign is_mem = (state == S_FETCH) || (state == S_LW1) ||
                  (state == S_SW)    || (state == S_LAS1) ||
                  (state == S_LAS3);

  // Halt is taken only on the first FETCH cycle, before any
  // request has been seen by memory.
  assign halting = (state == S_FETCH) && halt_req &&
                   (wait_cnt == '0);

  assign timeout = (MAX_WAIT != 0) && is_mem && !mem_ready &&
                   (wait_cnt == CNT_W'(CNT_MAX));

  function automatic logic [ALUOP_W-1:0] fmap(
    input logic [FUNC_W-1:0] f
  );
    if (f <= FUNC_W'(8))       fmap = ALUOP_W'(f);
    else if (f == FUNC_W'(9))  fmap = ALU_ADD;
    else if (f == FUNC_W'(10)) fmap = ALU_ADD;
    else if (f == FUNC_W'(12)) fmap = ALU_J;
    else                       fmap = '0;
  endfunction

  // Memory-state advance: halt, then ready, then timeout.
  function automatic logic [4:0] mem_next(
    input logic [4:0] nxt,
    input logic [4:0] cur
  );
    if (halting)        mem_next = S_HALT;
    else if (mem_ready) mem_next = nxt;
    else if (timeout)   mem_next = S_TRAP;
    else                mem_next = cur;
  endfunction

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = mem_next(S_DECODE, state);
      S_DECODE: begin
        case (opc)
          OPC_W'(0): state_next = S_RTYPE;
          OPC_W'(1): begin
            if (func == FUNC_W'(11))
              state_next = S_JALR;
            else if (func[FUNC_W-1 -: 2] == 2'b11)
              state_next = S_BRANCH;
            else
              state_next = S_RITYPE;
          end
          OPC_W'(2): state_next = S_RITYPE;
          OPC_W'(3): state_next = S_FETCH;
          OPC_W'(4): state_next = S_JAL;
          OPC_W'(5): state_next = S_LAS1;
          default:   state_next = S_TRAP;
        endcase
      end
      S_RTYPE:  state_next = S_RTYPEEND;
      S_RITYPE: begin
        if (func == FUNC_W'(9))
          state_next = S_LW1;
        else if (func == FUNC_W'(10))
          state_next = S_SW;
        else
          state_next = S_RTYPEEND;
      end
      S_LW1:    state_next = mem_next(S_LW2, state);
      S_SW:     state_next = mem_next(S_FETCH, state);
      S_BRANCH: state_next = S_BRANCH2;
      S_LAS1:   state_next = mem_next(S_LAS2, state);
      S_LAS2:   state_next = S_LAS3;
      S_LAS3:   state_next = mem_next(S_FETCH, state);
      S_TRAP:   state_next = trap_clear ? S_FETCH : S_TRAP;
      S_HALT:   state_next = halt_req ? S_HALT : S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Only completed instructions count; TRAP/HALT exits do not.
  always_comb begin
    retire = 1'b0;
    if (state_next == S_FETCH) begin
      case (state)
        S_RTYPEEND, S_LW2, S_SW, S_JALR,
        S_BRANCH2, S_JAL, S_LAS3, S_DECODE: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state         <= S_FETCH;
      wait_cnt      <= '0;
      instr_retired <= '0;
      trap_cause    <= 2'b00;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (is_mem && !mem_ready &&
               (wait_cnt != CNT_W'(CNT_MAX)))
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        instr_retired <= instr_retired + 1'b1;
      if (state == S_DECODE && state_next == S_TRAP)
        trap_cause <= C_ILL;
      else if (is_mem && state_next == S_TRAP)
        trap_cause <= C_TMO;
      else if (state == S_TRAP && trap_clear)
        trap_cause <= 2'b00;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    MemR       = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    Mem2Reg    = 1'b0;
    Branch     = 1'b0;
    keepALUOut = 1'b0;
    IoD        = 2'd0;
    ALUSrcA    = 3'd0;
    ALUSrcB    = 2'd0;
    BranchType = 2'd0;
    ALUOp      = '0;
    trap       = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        if (!halting) begin
          mem_req = 1'b1;
          MemR    = 1'b1;
          ALUSrcB = 2'd1;
          ALUOp   = ALU_ADD;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
      end
      S_DECODE: keepALUOut = 1'b1;
      S_RTYPE: begin
        ALUSrcA = 3'd2;
        ALUOp   = fmap(func);
      end
      S_RITYPE: begin
        ALUSrcA = 3'd2;
        ALUSrcB = 2'd2;
        Branch  = 1'b1;
        ALUOp   = fmap(func);
      end
      S_RTYPEEND: RegWrite = 1'b1;
      S_LW1: begin
        mem_req = 1'b1;
        MemR    = 1'b1;
        IoD     = 2'd1;
      end
      S_LW2: begin
        Mem2Reg  = 1'b1;
        RegWrite = 1'b1;
      end
      S_SW: begin
        mem_req = 1'b1;
        MemW    = 1'b1;
        IoD     = 2'd1;
      end
      S_LAS1: begin
        mem_req    = 1'b1;
        MemR       = 1'b1;
        IoD        = 2'd2;
        keepALUOut = 1'b1;
      end
      S_LAS2: begin
        ALUSrcA = 3'd4;
        ALUSrcB = 2'd2;
        ALUOp   = ALU_ADD;
      end
      S_LAS3: begin
        mem_req  = 1'b1;
        MemW     = 1'b1;
        IoD      = 2'd2;
        RegWrite = mem_ready;
      end
      S_JALR: begin
        ALUSrcA    = 3'd2;
        ALUSrcB    = 2'd2;
        ALUOp      = ALU_ADD;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        keepALUOut = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'd2;
        ALUOp      = ALU_ADD;
        Branch     = 1'b1;
        BranchType = func[1:0];
      end
      S_BRANCH2: begin
        ALUSrcA    = 3'd2;
        ALUOp      = ALU_SUB;
        Branch     = 1'b1;
        BranchType = func[1:0];
        PCSrc      = 1'b1;
        PCWrite    = 1'b1;
      end
      S_JAL: begin
        ALUSrcB  = 2'd2;
        ALUOp    = ALU_J;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign current_state = state;

endmodule

// File: tb/tb_lime_control_mc.sv
// tb_lime_control_mc: randomized self-checking bench for the
// lime multi-cycle control FSM against an instruction-level model.
module tb_lime_control_mc;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [6:0]  ic = 7'd0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        trap_clear = 1'b0;
  logic        mem_req, MemR, MemW, IRWrite, PCWrite, PCSrc;
  logic        RegWrite, Mem2Reg, Branch, keepALUOut;
  logic [1:0]  IoD, ALUSrcB, BranchType, trap_cause;
  logic [2:0]  ALUSrcA;
  logic [3:0]  ALUOp;
  logic [4:0]  current_state;
  logic        trap, halted;
  logic [15:0] instr_retired;
  logic [24:0] outs;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;
  int path[$];

  lime_control_mc #(
    .FUNC_W(4), .OPC_W(3), .ALUOP_W(4),
    .MAX_WAIT(15), .RETIRE_W(16)
  ) dut (
    .CLK(CLK), .Reset(Reset), .input_control(ic),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .trap_clear(trap_clear), .mem_req(mem_req),
    .MemR(MemR), .MemW(MemW), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .Mem2Reg(Mem2Reg), .Branch(Branch),
    .keepALUOut(keepALUOut), .IoD(IoD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .BranchType(BranchType), .ALUOp(ALUOp),
    .current_state(current_state), .trap(trap),
    .trap_cause(trap_cause), .halted(halted),
    .instr_retired(instr_retired)
  );

  always #5 CLK = ~CLK;

  assign outs = {mem_req, MemR, MemW, IRWrite, PCWrite, PCSrc,
                 RegWrite, Mem2Reg, Branch, keepALUOut, IoD,
                 ALUSrcA, ALUSrcB, BranchType, ALUOp, trap, halted};

  function automatic logic [3:0] fmap(input int f);
    if (f <= 8)       return 4'(f);
    else if (f == 12) return 4'd12;
    else              return 4'd0;
  endfunction

  function automatic bit is_mem(input int s);
    return s == 0 || s == 5 || s == 7 || s == 12 || s == 14;
  endfunction

  // Expected strobes per state; hz marks the halting FETCH cycle.
  function automatic logic [24:0] exp_out(input int st,
      input logic [6:0] c, input logic mr, input logic hz);
    logic mq, rd, wr, irw, pcw, pcs, rw, m2r, br, ka, tr, hl;
    logic [1:0] iod, sb, bt;
    logic [2:0] sa;
    logic [3:0] op;
    int f;
    {mq, rd, wr, irw, pcw, pcs, rw, m2r, br, ka, tr, hl} = '0;
    iod = 0; sb = 0; bt = 0; sa = 0; op = 0;
    f = int'(c[6:3]);
    case (st)
      0: if (!hz) begin
        mq = 1; rd = 1; sb = 1; irw = mr; pcw = mr;
      end
      1: ka = 1;
      2: begin sa = 2; op = fmap(f); end
      3: begin sa = 2; sb = 2; br = 1; op = fmap(f); end
      4: rw = 1;
      5: begin mq = 1; rd = 1; iod = 1; end
      6: begin m2r = 1; rw = 1; end
      7: begin mq = 1; wr = 1; iod = 1; end
      8: begin sa = 2; sb = 2; pcw = 1; rw = 1; ka = 1; end
      9: begin sb = 2; br = 1; bt = c[4:3]; end
      10: begin
        sa = 2; op = 1; br = 1; bt = c[4:3]; pcs = 1; pcw = 1;
      end
      11: begin sb = 2; op = 12; rw = 1; pcw = 1; end
      12: begin mq = 1; rd = 1; iod = 2; ka = 1; end
      13: begin sa = 4; sb = 2; end
      14: begin mq = 1; wr = 1; iod = 2; rw = mr; end
      15: tr = 1;
      16: hl = 1;
      default: ;
    endcase
    return {mq, rd, wr, irw, pcw, pcs, rw, m2r, br, ka, iod,
            sa, sb, bt, op, tr, hl};
  endfunction

  // States visited after FETCH for one instruction.
  task automatic build_path(input logic [6:0] c);
    int f, o;
    f = int'(c[6:3]);
    o = int'(c[2:0]);
    path.delete();
    path.push_back(1);
    if (o == 0) begin
      path.push_back(2); path.push_back(4);
    end else if (o == 1 && f == 11) begin
      path.push_back(8);
    end else if (o == 1 && f >= 12) begin
      path.push_back(9); path.push_back(10);
    end else if (o == 1 || o == 2) begin
      path.push_back(3);
      if (f == 9) begin
        path.push_back(5); path.push_back(6);
      end else if (f == 10) begin
        path.push_back(7);
      end else begin
        path.push_back(4);
      end
    end else if (o == 4) begin
      path.push_back(11);
    end else if (o == 5) begin
      path.push_back(12); path.push_back(13); path.push_back(14);
    end else if (o >= 6) begin
      path.push_back(15);
    end
  endtask

  task automatic drive(input logic mr, input logic hr);
    @(negedge CLK);
    mem_ready = mr;
    halt_req = hr;
    #1;
  endtask

  // fd < 0: random memory waits; otherwise fd waits on the
  // instruction's data access and none on FETCH.
  task automatic run_instr(input logic [6:0] c, input int fd);
    int seq[$];
    int d, last;
    logic [24:0] e;
    ic = c;
    build_path(c);
    seq = path;
    seq.push_front(0);
    foreach (seq[i]) begin
      d = 0;
      if (is_mem(seq[i])) begin
        if (fd < 0) d = $urandom_range(0, 4);
        else if (seq[i] != 0) d = fd;
      end
      for (int k = 0; k <= d; k++) begin
        drive(k == d, 1'b0);
        e = exp_out(seq[i], c, k == d, 1'b0);
        tests++;
        if (current_state !== 5'(seq[i]) || outs !== e) begin
          fails++;
          $display("FAIL seq ic=%h: state %0d outs %h, need %0d %h",
                   c, current_state, outs, seq[i], e);
        end
      end
    end
    last = seq[$];
    if (last != 15) exp_ret++;
    @(posedge CLK);
    #1;
    tests++;
    if (current_state !== (last == 15 ? 5'd15 : 5'd0) ||
        instr_retired !== 16'(exp_ret)) begin
      fails++;
      $display("FAIL end ic=%h: state %0d ret %0d, need ret %0d",
               c, current_state, instr_retired, exp_ret);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    #1;
    tests++;
    if (current_state !== 5'd0 || instr_retired !== 16'd0 ||
        trap_cause !== 2'd0) begin
      fails++;
      $display("FAIL reset: state %0d ret %0d cause %0d, need 0",
               current_state, instr_retired, trap_cause);
    end
    tests++;
    if (outs !== exp_out(0, ic, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL reset_outs: %h, need %h", outs,
               exp_out(0, ic, 1'b0, 1'b0));
    end
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic clear_trap(input logic [1:0] cause);
    @(negedge CLK);
    mem_ready = 1'b0;
    #1;
    tests++;
    if (current_state !== 5'd15 || trap_cause !== cause ||
        trap !== 1'b1) begin
      fails++;
      $display("FAIL trap_hold: state %0d cause %0d, need 15 %0d",
               current_state, trap_cause, cause);
    end
    @(negedge CLK);
    trap_clear = 1'b1;
    #1;
    tests++;
    if (current_state !== 5'd15) begin
      fails++;
      $display("FAIL trap_clr0: state %0d, need 15", current_state);
    end
    @(negedge CLK);
    trap_clear = 1'b0;
    #1;
    tests++;
    if (current_state !== 5'd0 || trap_cause !== 2'd0 ||
        instr_retired !== 16'(exp_ret)) begin
      fails++;
      $display("FAIL trap_exit: state %0d cause %0d ret %0d",
               current_state, trap_cause, instr_retired);
    end
  endtask

  task automatic test_random();
    logic [3:0] f;
    logic [2:0] o;
    repeat (40) begin
      f = 4'($urandom_range(0, 15));
      o = 3'($urandom_range(0, 5));
      run_instr({f, o}, -1);
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0);
      tests++;
      if (current_state !== 5'd0 ||
          outs !== exp_out(0, ic, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL tmo_wait k=%0d: state %0d outs %h",
                 k, current_state, outs);
      end
    end
    clear_trap(2'b10);
  endtask

  task automatic test_illegal();
    run_instr(7'b0101_110, 0);
    clear_trap(2'b01);
    run_instr(7'b0000_111, 0);
    clear_trap(2'b01);
  endtask

  task automatic test_halt();
    ic = 7'b0000_100;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    tests++;
    if (current_state !== 5'd11 ||
        outs !== exp_out(11, ic, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL halt_jal: state %0d outs %h", current_state, outs);
    end
    exp_ret++;
    drive(1'b0, 1'b1);
    tests++;
    if (current_state !== 5'd0 || instr_retired !== 16'(exp_ret) ||
        outs !== exp_out(0, ic, 1'b0, 1'b1)) begin
      fails++;
      $display("FAIL halt_fetch: state %0d ret %0d outs %h",
               current_state, instr_retired, outs);
    end
    repeat (3) begin
      drive(1'b0, 1'b1);
      tests++;
      if (current_state !== 5'd16 ||
          outs !== exp_out(16, ic, 1'b0, 1'b0)) begin
        fails++;
        $display("FAIL halt_park: state %0d outs %h",
                 current_state, outs);
      end
    end
    ic = 7'b0000_011;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    tests++;
    if (current_state !== 5'd0 ||
        outs !== exp_out(0, ic, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL halt_exit: state %0d outs %h",
               current_state, outs);
    end
    drive(1'b1, 1'b0);
    exp_ret++;
    @(posedge CLK);
    #1;
    tests++;
    if (current_state !== 5'd0 || instr_retired !== 16'(exp_ret)) begin
      fails++;
      $display("FAIL halt_nop: state %0d ret %0d, need 0 %0d",
               current_state, instr_retired, exp_ret);
    end
  endtask

  task automatic test_las_reset();
    ic = 7'b0000_101;
    repeat (4) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    tests++;
    if (current_state !== 5'd14 ||
        outs !== exp_out(14, ic, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL las3_wait: state %0d outs %h",
               current_state, outs);
    end
    drive(1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    exp_ret = 0;
    tests++;
    if (current_state !== 5'd0 || instr_retired !== 16'd0 ||
        outs !== exp_out(0, ic, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL las_reset: state %0d ret %0d outs %h",
               current_state, instr_retired, outs);
    end
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    run_instr(7'b0000_000, 0);
    run_instr(7'b1001_001, 3);
    run_instr(7'b1010_010, 2);
    run_instr(7'b1101_001, 0);
    test_random();
    test_timeout();
    test_illegal();
    test_halt();
    test_las_reset();
    run_instr(7'b0011_000, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
